// File: rtl/bc_input_ctrl.sv
// Base-converter input front end: synchronizes the switches and keys, debounces them, and produces B_out and op.
// Optional BC_INPUT_AUTOLOAD_EN also reloads B_out once sw has been stable and different from it for DEBOUNCE_CYCLES.

module bc_key_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_s,
  output logic press
);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s)                  state_d = RELEASED;
        else if (cnt_q == CNT_LAST) state_d = PRESSED;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s)                 state_d = PRESSED;
        else if (cnt_q == CNT_LAST) state_d = RELEASED;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = RELEASED;
    endcase
  end

  // Combinational hit; the parent registers it so strobe and data update share an edge.
  always_comb begin
    press = (state_q == PRESS_WAIT) && !key_s && (cnt_q == CNT_LAST);
  end
endmodule

module bc_input_ctrl #(
  parameter int unsigned N               = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic         key_load_n,
  input  logic         key_mode_n,
  output logic [N-1:0] B_out,
  output logic [1:0]   op,
  output logic         load_pulse,
  output logic         mode_pulse
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic         kl_meta_q, kl_meta_d, kl_sync_q, kl_sync_d;
  logic         km_meta_q, km_meta_d, km_sync_q, km_sync_d;
  logic [N-1:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [N-1:0] b_out_q, b_out_d;
  logic [1:0]   op_q, op_d;
  logic         load_pulse_q, load_pulse_d;
  logic         mode_pulse_q, mode_pulse_d;
  logic         load_press, mode_press, load_fire;

  bc_key_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_load_fsm (
    .clk(clk), .rst_n(rst_n), .key_s(kl_sync_q), .press(load_press)
  );

  bc_key_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mode_fsm (
    .clk(clk), .rst_n(rst_n), .key_s(km_sync_q), .press(mode_press)
  );

`ifdef BC_INPUT_AUTOLOAD_EN
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;
  logic [N-1:0]     sw_prev_q, sw_prev_d;
  logic             auto_run, auto_hit;

  always_comb begin
    auto_run  = (sw_sync_q != b_out_q) && (sw_sync_q == sw_prev_q);
    auto_hit  = auto_run && (auto_cnt_q == AUTO_LAST);
    load_fire = load_press | auto_hit;
    // A key load also satisfies the pending auto-load, so both collapse into one pulse.
    auto_cnt_d = (!auto_run || load_fire) ? '0 : auto_cnt_q + 1'b1;
    sw_prev_d  = sw_sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt_q <= '0;
      sw_prev_q  <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
      sw_prev_q  <= sw_prev_d;
    end
  end
`else
  always_comb begin
    load_fire = load_press;
  end
`endif

  always_comb begin
    kl_meta_d    = key_load_n;
    kl_sync_d    = kl_meta_q;
    km_meta_d    = key_mode_n;
    km_sync_d    = km_meta_q;
    sw_meta_d    = sw;
    sw_sync_d    = sw_meta_q;
    b_out_d      = b_out_q;
    op_d         = op_q;
    load_pulse_d = load_fire;
    mode_pulse_d = mode_press;
    if (load_fire)  b_out_d = sw_sync_q;
    if (mode_press) op_d    = op_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kl_meta_q    <= 1'b1;
      kl_sync_q    <= 1'b1;
      km_meta_q    <= 1'b1;
      km_sync_q    <= 1'b1;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      b_out_q      <= '0;
      op_q         <= 2'b00;
      load_pulse_q <= 1'b0;
      mode_pulse_q <= 1'b0;
    end else begin
      kl_meta_q    <= kl_meta_d;
      kl_sync_q    <= kl_sync_d;
      km_meta_q    <= km_meta_d;
      km_sync_q    <= km_sync_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      b_out_q      <= b_out_d;
      op_q         <= op_d;
      load_pulse_q <= load_pulse_d;
      mode_pulse_q <= mode_pulse_d;
    end
  end

  always_comb begin
    B_out      = b_out_q;
    op         = op_q;
    load_pulse = load_pulse_q;
    mode_pulse = mode_pulse_q;
  end
endmodule
